// File: rtl/decimal_entry.sv
// decimal_entry: BCD digit entry with sequential BCD-to-binary conversion; define DEC_ENTRY_ROLL_EN to let a full entry roll (discard MSD) on enter
module decimal_entry #(
  parameter int DIGITS = 4,
  parameter int WIDTH = 14,
  parameter int CW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            digit_in,
  input  logic                  enter_pulse,
  input  logic                  back_pulse,
  input  logic                  clear_pulse,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [CW-1:0]         count_out,
  output logic [WIDTH-1:0]      bin_out,
  output logic                  bin_valid,
  output logic                  busy,
  output logic                  err
);
`ifdef DEC_ENTRY_ROLL_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif
  typedef enum logic {IDLE, CONV} state_t;
  state_t state;
  logic [CW-1:0] idx;
  logic [WIDTH-1:0] acc;
  logic [4*DIGITS-1:0] shifted;
  logic [3:0] cur;
  logic [WIDTH+3:0] wide;
  logic full, accept;
  // Digit select, acc*10+digit via shifts, and enter acceptance
  always_comb begin
    shifted = bcd_out >> {idx, 2'b00};
    cur = shifted[3:0];
    wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{WIDTH{1'b0}}, cur};
    full = count_out == CW'(DIGITS);
    accept = (digit_in <= 4'd9) && (ROLL || !full);
  end
  // Conversion step first; an edit later in the block overrides it and restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= '0;
      count_out <= '0;
      bin_out <= '0;
      bin_valid <= 1'b1;
      busy <= 1'b0;
      err <= 1'b0;
      state <= IDLE;
      idx <= '0;
      acc <= '0;
    end else begin
      if (state == CONV) begin
        acc <= wide[WIDTH-1:0];
        idx <= idx - 1'b1;
        if (idx == '0) begin
          bin_out <= wide[WIDTH-1:0];
          bin_valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
          idx <= '0;
        end
      end
      if (clear_pulse) begin
        bcd_out <= '0;
        count_out <= '0;
        err <= 1'b0;
        bin_out <= '0;
        bin_valid <= 1'b1;
        busy <= 1'b0;
        state <= IDLE;
        idx <= '0;
        acc <= '0;
      end else if (back_pulse) begin
        if (count_out != '0) begin
          bcd_out <= {4'h0, bcd_out[4*DIGITS-1:4]};
          count_out <= count_out - 1'b1;
          err <= 1'b0;
          busy <= 1'b1;
          bin_valid <= 1'b0;
          state <= CONV;
          idx <= CW'(DIGITS - 1);
          acc <= '0;
        end
      end else if (enter_pulse) begin
        if (accept) begin
          bcd_out <= {bcd_out[4*DIGITS-5:0], digit_in};
          count_out <= full ? count_out : count_out + 1'b1;
          err <= 1'b0;
          busy <= 1'b1;
          bin_valid <= 1'b0;
          state <= CONV;
          idx <= CW'(DIGITS - 1);
          acc <= '0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_decimal_entry.sv
// tb_decimal_entry: table vectors, corner sequences and random stimulus against an arithmetic model
module tb_decimal_entry;
  localparam int DIGITS = 4, WIDTH = 14, CW = 3;
  localparam int MAXV = 10 ** DIGITS;
`ifdef DEC_ENTRY_ROLL_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif
  logic clk = 1'b0, rst, enter_pulse, back_pulse, clear_pulse;
  logic [3:0] digit_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [CW-1:0] count_out;
  logic [WIDTH-1:0] bin_out;
  logic bin_valid, busy, err;
  int checks = 0, errors = 0;
  int m_val, m_cnt, m_bin, m_timer;
  bit m_valid, m_err;
  typedef struct {
    bit c, b, e;
    logic [3:0] d;
    int idle;
    int bcd, cnt, bin;
    bit valid, bsy, er;
  } vec_t;
  vec_t tbl[$];

  decimal_entry #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .enter_pulse(enter_pulse),
    .back_pulse(back_pulse), .clear_pulse(clear_pulse), .bcd_out(bcd_out),
    .count_out(count_out), .bin_out(bin_out), .bin_valid(bin_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(int v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_cnt = 0; m_bin = 0; m_timer = 0; m_valid = 1; m_err = 0;
  endtask

  task automatic model_step(bit c, bit b, bit e, int d);
    if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) begin
        m_bin = m_val;
        m_valid = 1;
      end
    end
    if (c) begin
      m_val = 0; m_cnt = 0; m_err = 0; m_bin = 0; m_valid = 1; m_timer = 0;
    end else if (b) begin
      if (m_cnt > 0) begin
        m_val = m_val / 10; m_cnt--; m_err = 0; m_timer = DIGITS; m_valid = 0;
      end
    end else if (e) begin
      if (d > 9 || (m_cnt == DIGITS && !ROLL)) m_err = 1;
      else begin
        m_val = (m_val * 10 + d) % MAXV;
        if (m_cnt < DIGITS) m_cnt++;
        m_err = 0; m_timer = DIGITS; m_valid = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("bcd", int'(bcd_out), to_bcd(m_val));
    chk("count", int'(count_out), m_cnt);
    chk("bin", int'(bin_out), m_bin);
    chk("valid", int'(bin_valid), int'(m_valid));
    chk("busy", int'(busy), int'(m_timer > 0));
    chk("err", int'(err), int'(m_err));
  endtask

  task automatic cyc(bit c, bit b, bit e, logic [3:0] d);
    clear_pulse = c; back_pulse = b; enter_pulse = e; digit_in = d;
    @(posedge clk);
    #1;
    model_step(c, b, e, int'(d));
    check_model();
    clear_pulse = 0; back_pulse = 0; enter_pulse = 0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 4'd0);
  endtask

  task automatic chk_all(string name, int bcd, int cnt, int bin, bit v, bit bs, bit er);
    chk({name, ".bcd"}, int'(bcd_out), bcd);
    chk({name, ".count"}, int'(count_out), cnt);
    chk({name, ".bin"}, int'(bin_out), bin);
    chk({name, ".valid"}, int'(bin_valid), int'(v));
    chk({name, ".busy"}, int'(busy), int'(bs));
    chk({name, ".err"}, int'(err), int'(er));
  endtask

  initial begin
    rst = 1; enter_pulse = 0; back_pulse = 0; clear_pulse = 0; digit_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 1, 0, 0);
    rst = 0;
    tbl.push_back('{0,0,1,4'd1,9,'h1,1,1,1,0,0});
    tbl.push_back('{0,0,1,4'd2,9,'h12,2,12,1,0,0});
    tbl.push_back('{0,0,1,4'd3,0,'h123,3,12,0,1,0});
    tbl.push_back('{0,0,0,4'd0,2,'h123,3,12,0,1,0});
    tbl.push_back('{0,0,0,4'd0,0,'h123,3,123,1,0,0});
    tbl.push_back('{0,1,0,4'd0,9,'h12,2,12,1,0,0});
    tbl.push_back('{0,1,0,4'd0,9,'h1,1,1,1,0,0});
    tbl.push_back('{0,1,0,4'd0,9,'h0,0,0,1,0,0});
    tbl.push_back('{0,1,0,4'd0,0,'h0,0,0,1,0,0});
    tbl.push_back('{0,0,1,4'd9,9,'h9,1,9,1,0,0});
    tbl.push_back('{0,0,1,4'd9,9,'h99,2,99,1,0,0});
    tbl.push_back('{0,0,1,4'd9,9,'h999,3,999,1,0,0});
    tbl.push_back('{0,0,1,4'd9,9,'h9999,4,9999,1,0,0});
    tbl.push_back('{0,0,1,4'd5,9,ROLL ? 'h9995 : 'h9999,4,ROLL ? 9995 : 9999,1,0,!ROLL});
    tbl.push_back('{0,0,1,4'hC,9,ROLL ? 'h9995 : 'h9999,4,ROLL ? 9995 : 9999,1,0,1});
    tbl.push_back('{1,0,0,4'd0,2,'h0,0,0,1,0,0});
    tbl.push_back('{0,0,1,4'hC,9,'h0,0,0,1,0,1});
    tbl.push_back('{0,0,1,4'd7,9,'h7,1,7,1,0,0});
    tbl.push_back('{1,0,1,4'd3,0,'h0,0,0,1,0,0});
    foreach (tbl[i]) begin
      cyc(tbl[i].c, tbl[i].b, tbl[i].e, tbl[i].d);
      idle(tbl[i].idle);
      chk_all($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].cnt, tbl[i].bin, tbl[i].valid, tbl[i].bsy, tbl[i].er);
    end
    // edit during conversion restarts it
    cyc(0, 0, 1, 4'd4);
    idle(1);
    cyc(0, 0, 1, 4'd5);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      chk("restart.valid", int'(bin_valid), int'(k == 4));
      chk("restart.bin", int'(bin_out), k == 4 ? 45 : 0);
    end
    cyc(1, 0, 1, 4'd6);
    chk_all("clear_wins", 0, 0, 0, 1, 0, 0);
    // asynchronous reset mid-conversion
    cyc(0, 0, 1, 4'd8);
    idle(5);
    cyc(0, 0, 1, 4'd1);
    idle(1);
    #2 rst = 1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1, 0, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    cyc(0, 0, 1, 4'd2);
    idle(4);
    chk_all("after_rst", 'h2, 1, 2, 1, 0, 0);
    // random pulses, including simultaneous ones and invalid digits
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) == 0, 4'($urandom_range(0, 11)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decimal_entry.md
Name: decimal_entry

Overview:
Consumes the single-cycle pulses from the button pulser stage and assembles a multi-digit decimal number from a 4-bit digit switch value.
- Keeps the entered digits as a BCD shift register for the display path.
- After every edit, runs a sequential BCD-to-binary conversion (one digit per clock) and presents the binary result with a valid flag to the binary display logic downstream.

Parameters:
DIGITS, 4, number of decimal digits held (max value 10^DIGITS-1)
WIDTH, 14, binary result width; must be at least ceil(log2(10^DIGITS))
CW, 3, digit-count width; must be at least clog2(DIGITS+1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
digit_in  in  4  BCD digit from switches, sampled on enter_pulse
enter_pulse  in  1  one-cycle pulse: append digit
back_pulse  in  1  one-cycle pulse: delete last digit
clear_pulse  in  1  one-cycle pulse: clear entry
bcd_out  out  4*DIGITS  entered digits, LSD in [3:0], unused upper digits 0
count_out  out  CW  number of digits entered, 0..DIGITS
bin_out  out  WIDTH  binary value of bcd_out, valid when bin_valid=1
bin_valid  out  1  bin_out matches bcd_out
busy  out  1  conversion in progress
err  out  1  sticky: last enter rejected

Behaviour:
- Reset (async, any time including mid-conversion): bcd_out=0, count_out=0, bin_out=0, bin_valid=1, busy=0, err=0, FSM=IDLE, conversion index=0.
- Simultaneous pulses in one cycle: clear > back > enter. Only the highest-priority pulse acts.
- clear: bcd=0, count=0, err=0, bin_out=0, bin_valid=1, busy=0, FSM=IDLE next edge. Aborts any conversion.
- enter, digit_in>9: rejected, err=1, nothing else changes.
- enter, count==DIGITS: rejected, err=1, nothing else changes (see optional feature).
- enter, accepted: bcd <= {bcd[4*DIGITS-5:0], digit_in}, count+1, err=0, start conversion.
- back, count==0: no-op, err unchanged, no conversion.
- back, count>0: bcd <= {4'h0, bcd[4*DIGITS-1:4]}, count-1, err=0, start conversion.
- Start conversion: on the edit edge set busy=1, bin_valid=0, FSM=CONV, idx=DIGITS-1, acc=0.
- FSM CONV: each clock, acc <= acc*10 + bcd digit[idx] and idx decrements. acc*10 is computed as (acc<<3)+(acc<<1) in WIDTH+4 bits, then truncated to WIDTH.
- The step at idx==0 writes bin_out=result, sets bin_valid=1 and busy=0, and returns FSM to IDLE.
- Conversion latency: exactly DIGITS clocks from the accepting edge to the bin_valid=1 edge. Leading zero digits are processed normally.
- Accepted edit during CONV: bcd/count update as above and conversion restarts (idx=DIGITS-1, acc=0). bin_valid stays 0 and the latency counts from the new edit.
- Rejected enter or no-op back during CONV: conversion continues unaffected.
- bin_out holds its previous value while busy. Consumers use it only when bin_valid=1.
- Inputs are assumed already synchronous single-cycle pulses. A pulse held high for N cycles acts N times.

Optional Feature:
DEC_ENTRY_ROLL_EN
- Defined: enter with count==DIGITS and a valid digit is accepted. The MSD is discarded, the shift-in proceeds, count stays DIGITS, err=0, and conversion starts.
- Undefined: this case is rejected with err=1 as above.
- Invalid digits (>9) are rejected in both builds.

Test Plan:
1. Reset, then enter 1,2,3 (one pulse every 10 clocks) -> bcd_out=16'h0123, count_out=3; bin_out=123 and bin_valid=1 exactly 4 clocks after the last enter, busy high for those 4 clocks.
2. From 0123, back pulse -> bcd_out=16'h0012, count_out=2, bin_out=12 after 4 clocks; back x3 more -> count_out=0, bcd 0, bin_out=0, final back causes no busy.
3. Enter 9,9,9,9 then enter 5 -> without ROLL: err=1, bcd 16'h9999, bin_out=9999. With DEC_ENTRY_ROLL_EN: bcd 16'h9995, bin_out=9995, err=0.
4. digit_in=4'hC with enter -> err=1, bcd/count/bin unchanged; next accepted enter of 7 -> err=0.
5. Enter 4, then enter 5 two clocks later (mid-conversion) -> bin_valid stays 0 until 4 clocks after second enter, bin_out=45, never shows 4. Then clear_pulse and enter_pulse in the same cycle -> clear wins: all zero, bin_valid=1, busy=0.
6. Assert rst mid-conversion (after entering 8,1) -> outputs immediately return to reset values asynchronously; after release, enter 2 -> bin_out=2.
